dma_rd: RTL and testbench
=========================

Name: dma_rd

Overview:
- Parametrised successor to the single-purpose frame DMA: an AXI3 read master on a Zynq HP port that streams a byte range from DDR into the pixel FIFO.
- Adds configurable data width, burst length and outstanding-burst depth.
- Adds 4 KB-boundary and tail-burst truncation, an abort path, and a sticky response-error flag.
- Sits between regs/stuff control (start, address window) and the PS7 SAXIHP read channels; the FIFO write side is in the same clock.

Parameters:
- DATA_W, 64, AXI read data width in bits; one of 32 or 64. BYTES = DATA_W/8.
- BURST_LEN, 16, maximum beats per burst, 1..16 (AXI3).
- MAX_OUTST, 4, maximum bursts issued but not yet completed, 1..15.
- ADDR_W, 32, address width.
- ID_W, 12, AXI ID width.
- AXI_ID, 0, constant value driven on arid.

Ports:
- clk  in  1  fabric clock; all logic is on the rising edge.
- resetn  in  1  asynchronous active-low reset.
- start  in  1  single-cycle pulse that begins a transfer.
- abort  in  1  single-cycle pulse that stops the current transfer.
- addrstart  in  ADDR_W  first byte address; low log2(BYTES) bits are ignored.
- addrend  in  ADDR_W  exclusive end byte address; low bits are ignored.
- busy  out  1  high from the accepted start until the block returns to IDLE.
- done  out  1  one-cycle pulse on normal completion.
- err  out  1  sticky; set by any rresp != 0.
- fifo_di  out  DATA_W  registered copy of rdata.
- fifo_wren  out  1  write strobe for fifo_di.
- fifo_alfull  in  1  FIFO almost-full.
- araddr  out  ADDR_W; arid  out  ID_W; arlen  out  4; arsize  out  3; arburst  out  2; arvalid  out  1; arready  in  1.
- rdata  in  DATA_W; rid  in  ID_W; rresp  in  2; rlast  in  1; rvalid  in  1; rready  out  1.

Behaviour:
- Reset values: busy, done, err, fifo_wren, arvalid = 0; araddr, arlen = 0; rready = 1; fifo_di = 0. Reset is asynchronous assert; deassertion is synchronous to clk.
- Constant outputs: arsize = log2(BYTES); arburst = 2'b01 (INCR); arid = AXI_ID.
- rready is held at 1 in every state; beats are never back-pressured.
- States:
  - IDLE: start latches cur = addrstart & ~(BYTES-1) and end = addrend & ~(BYTES-1), clears err, sets busy. Next state is ISSUE if cur < end, otherwise DONE.
  - ISSUE: computes beats = min(BURST_LEN, (end-cur)/BYTES, (4096 - cur[11:0])/BYTES).
    - Drives arvalid only when outst < MAX_OUTST and !fifo_alfull.
    - araddr/arlen = cur/beats-1, held stable while arvalid && !arready.
    - On handshake: cur += beats*BYTES and outst increments. If the new cur >= end, go to DRAIN.
  - DRAIN: waits until outst == 0, then goes to DONE.
  - DONE: done = 1 for exactly one cycle, busy = 0, then IDLE.
  - ABORT: entered from ISSUE or DRAIN on abort.
    - If arvalid is pending it is held until its handshake completes (AXI rule), and that burst is counted.
    - No further bursts are issued.
    - Waits until outst == 0, then goes to IDLE with busy = 0 and no done pulse.
- outst counter: +1 on an AR handshake; -1 on rvalid & rlast. Both in the same cycle leaves it unchanged.
- Data path: in ISSUE or DRAIN, each rvalid beat gives fifo_wren = 1 and fifo_di = rdata on the next cycle (1-cycle latency).
  - In ABORT and IDLE, beats are accepted and discarded.
  - rid is ignored, since all bursts use AXI_ID and return in order.
- Any rresp != 0 beat sets err. The beat is still written, and the transfer continues.
- Simultaneous events:
  - start while busy is ignored.
  - abort in IDLE or DONE is ignored.
  - abort and start in the same IDLE cycle: start wins.
  - fifo_alfull rising while arvalid is already high does not withdraw arvalid.
- Reset mid-transfer returns all state to reset values immediately; the system resets the PS HP port alongside.

Test Plan:
- DATA_W=64, BURST_LEN=16, addrstart=0x1000, addrend=0x1200, arready=1 -> ARs at 0x1000/0x1080/0x1100/0x1180 with arlen=15, arsize=3, arburst=1; 64 fifo_wren; done 1 cycle after outst reaches 0 following the last rlast.
- addrstart=0x1FC0, addrend=0x2100 -> ARs 0x1FC0 len 7, 0x2000 len 15, 0x2080 len 15; 40 writes total. addrstart=0x1003, addrend=0x1018 -> single AR 0x1000 len 2.
- MAX_OUTST=4, rvalid held 0, addrend-addrstart=0x1000 -> exactly 4 ARs, then arvalid stays 0; the first rlast allows a 5th AR.
- fifo_alfull=1 from start -> no arvalid. Deassert -> issuing resumes. Assert mid-stream -> in-flight beats are still written, and no new AR is issued after the pending one handshakes.
- abort after 2 ARs with burst 1 half returned -> no 3rd AR; remaining beats are not written; busy falls after the 2nd rlast; done never pulses. A following start works normally.
- rresp=2 on beat 5 -> err=1 from the next cycle, all beats still written, done pulses; err stays 1 until the next start. addrend <= addrstart -> no AR, done 2 cycles after start.

Source files
------------

// File: rtl/dma_rd.sv
// rtl/dma_rd.sv - AXI3 read master streaming an aligned byte range into the pixel FIFO
module dma_rd #(
  parameter int DATA_W    = 64,
  parameter int BURST_LEN = 16,
  parameter int MAX_OUTST = 4,
  parameter int ADDR_W    = 32,
  parameter int ID_W      = 12,
  parameter int AXI_ID    = 0
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] addrstart,
  input  logic [ADDR_W-1:0] addrend,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [DATA_W-1:0] fifo_di,
  output logic              fifo_wren,
  input  logic              fifo_alfull,
  output logic [ADDR_W-1:0] araddr,
  output logic [ID_W-1:0]   arid,
  output logic [3:0]        arlen,
  output logic [2:0]        arsize,
  output logic [1:0]        arburst,
  output logic              arvalid,
  input  logic              arready,
  input  logic [DATA_W-1:0] rdata,
  input  logic [ID_W-1:0]   rid,
  input  logic [1:0]        rresp,
  input  logic              rlast,
  input  logic              rvalid,
  output logic              rready
);

  localparam int BYTES = DATA_W / 8;
  localparam int LOG_BYTES = $clog2(BYTES);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~(ADDR_W'(BYTES - 1));

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE, S_ABORT} state_t;

  state_t            state;
  logic [ADDR_W-1:0] cur;
  logic [ADDR_W-1:0] end_addr;
  logic [3:0]        outst;
  logic [3:0]        outst_nxt;
  logic [ADDR_W-1:0] start_cur;
  logic [ADDR_W-1:0] start_end;
  logic [ADDR_W-1:0] rem_beats;
  logic [12:0]       page_beats;
  logic [4:0]        beats;
  logic [ADDR_W-1:0] next_cur;
  logic              ar_hs;
  logic              r_last;
  logic              can_issue;
  logic              unused_rid;

  // All bursts share one ID and return in order, so rid carries no information.
  assign unused_rid = ^rid;

  assign arid    = ID_W'(AXI_ID);
  assign arsize  = 3'(LOG_BYTES);
  assign arburst = 2'b01;
  assign rready  = 1'b1;

  assign start_cur  = addrstart & ALIGN_MASK;
  assign start_end  = addrend & ALIGN_MASK;
  assign rem_beats  = (end_addr - cur) >> LOG_BYTES;
  assign page_beats = (13'h1000 - {1'b0, cur[11:0]}) >> LOG_BYTES;
  assign next_cur   = cur + ((ADDR_W'(arlen) + ADDR_W'(1)) << LOG_BYTES);
  assign ar_hs      = arvalid & arready;
  assign r_last     = rvalid & rlast;
  assign can_issue  = (outst < 4'(MAX_OUTST)) && !fifo_alfull;

  // Burst never crosses a 4 KB page nor runs past the end of the window.
  always_comb begin
    beats = 5'(BURST_LEN);
    if (rem_beats < ADDR_W'(BURST_LEN)) beats = 5'(rem_beats);
    if (page_beats < 13'(beats)) beats = 5'(page_beats);
  end

  always_comb begin
    outst_nxt = outst;
    if (ar_hs && !r_last) outst_nxt = outst + 4'd1;
    else if (!ar_hs && r_last && outst != 4'd0) outst_nxt = outst - 4'd1;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= S_IDLE;
      cur       <= '0;
      end_addr  <= '0;
      outst     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      fifo_di   <= '0;
      fifo_wren <= 1'b0;
      araddr    <= '0;
      arlen     <= '0;
      arvalid   <= 1'b0;
    end else begin
      outst     <= outst_nxt;
      done      <= 1'b0;
      fifo_wren <= 1'b0;
      if (rvalid && (state == S_ISSUE || state == S_DRAIN)) begin
        fifo_wren <= 1'b1;
        fifo_di   <= rdata;
      end
      if (rvalid && rresp != 2'b00) err <= 1'b1;

      case (state)
        S_IDLE: begin
          if (start) begin
            cur      <= start_cur;
            end_addr <= start_end;
            err      <= 1'b0;
            busy     <= 1'b1;
            state    <= (start_cur < start_end) ? S_ISSUE : S_DONE;
          end
        end
        S_ISSUE: begin
          if (arvalid) begin
            if (arready) begin
              arvalid <= 1'b0;
              cur     <= next_cur;
              if (next_cur >= end_addr) state <= S_DRAIN;
            end
          end else if (can_issue && !abort) begin
            arvalid <= 1'b1;
            araddr  <= cur;
            arlen   <= 4'(beats - 5'd1);
          end
          if (abort) state <= S_ABORT;
        end
        S_DRAIN: begin
          if (abort) state <= S_ABORT;
          else if (outst_nxt == 4'd0) state <= S_DONE;
        end
        S_DONE: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        S_ABORT: begin
          // A pending AR must still complete; its burst is then drained and dropped.
          if (ar_hs) arvalid <= 1'b0;
          if (!arvalid && outst_nxt == 4'd0) begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dma_rd.sv
// tb/tb_dma_rd.sv - directed bench for dma_rd with an AXI slave model and FIFO scoreboard
module tb_dma_rd;

  logic        clk = 1'b0;
  logic        resetn, start, abort;
  logic [31:0] addrstart, addrend;
  logic        busy, done, err;
  logic [63:0] fifo_di;
  logic        fifo_wren, fifo_alfull;
  logic [31:0] araddr;
  logic [11:0] arid;
  logic [3:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arvalid, arready;
  logic [63:0] rdata;
  logic [11:0] rid;
  logic [1:0]  rresp;
  logic        rlast, rvalid, rready;

  always #5 clk = ~clk;

  dma_rd #(.DATA_W(64), .BURST_LEN(16), .MAX_OUTST(4), .ADDR_W(32), .ID_W(12), .AXI_ID(0)) dut (
    .clk(clk), .resetn(resetn), .start(start), .abort(abort),
    .addrstart(addrstart), .addrend(addrend), .busy(busy), .done(done), .err(err),
    .fifo_di(fifo_di), .fifo_wren(fifo_wren), .fifo_alfull(fifo_alfull),
    .araddr(araddr), .arid(arid), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready), .rdata(rdata), .rid(rid), .rresp(rresp),
    .rlast(rlast), .rvalid(rvalid), .rready(rready)
  );

  typedef struct {logic [31:0] addr; int len;} burst_t;

  burst_t      exp_ar[$];
  burst_t      pend[$];
  logic [63:0] exp_wr[$];
  int n_tests = 0, n_fail = 0;
  int cyc = 0, ar_count = 0, wr_count = 0, done_cnt = 0, arv_cycles = 0;
  int beat_idx = 0, beat_in_burst = 0, xfer_beats = 0, last_rlast_cyc = 0;
  int r_budget = 1000000, ar_limit = 1000000, alfull_at_ar = 1000000, bad_beat = -1;
  bit r_en = 1'b1, force_alfull = 1'b0, aborted = 1'b0, bad_pend = 1'b0, prev_busy = 1'b0;
  bit prev_arv_wait = 1'b0;
  logic        err_before = 1'b0;
  logic [31:0] prev_araddr = '0;
  logic [3:0]  prev_arlen = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference burst split: page-limited, tail-limited, at most 16 beats of 8 bytes.
  function automatic void gen_ars(input logic [31:0] s, input logic [31:0] e);
    logic [31:0] a, ee;
    int n;
    a  = s & ~32'h7;
    ee = e & ~32'h7;
    while (a < ee) begin
      n = 16;
      if ((ee - a) / 8 < n) n = int'((ee - a) / 8);
      if ((4096 - (a % 4096)) / 8 < n) n = int'((4096 - (a % 4096)) / 8);
      exp_ar.push_back('{a, n - 1});
      a = a + 32'(n * 8);
    end
  endfunction

  // Slave and scoreboard: sample outputs of the last rising edge, then drive the next one.
  always @(negedge clk) begin : slave
    burst_t b;
    cyc++;
    if (fifo_wren) begin
      wr_count++;
      if (exp_wr.size() == 0) chk("fifo_unexpected_write", 1, 0);
      else chk("fifo_di", fifo_di, exp_wr.pop_front());
    end
    if (done) begin
      done_cnt++;
      chk("busy_at_done", busy, 0);
      if (xfer_beats > 0) chk("done_latency", cyc - last_rlast_cyc, 2);
    end
    if (bad_pend) begin
      chk("err_before_bad_beat", err_before, 0);
      chk("err_after_bad_beat", err, 1);
      bad_pend = 1'b0;
    end
    if (prev_busy && !busy) chk("bursts_open_at_idle", pend.size(), 0);
    prev_busy = busy;
    if (prev_arv_wait) begin
      chk("ar_hold_valid", arvalid, 1);
      chk("ar_hold_addr", araddr, prev_araddr);
      chk("ar_hold_len", arlen, prev_arlen);
    end
    if (arvalid) arv_cycles++;

    rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00;
    if (r_en && r_budget > 0 && pend.size() > 0) begin
      b = pend[0];
      rvalid = 1'b1;
      rdata  = {32'hC0DE0000 + 32'(beat_idx), b.addr + 32'(beat_in_burst * 8)};
      rlast  = (beat_in_burst == b.len);
      if (beat_idx == bad_beat) begin
        rresp = 2'b10;
        bad_pend = 1'b1;
        err_before = err;
      end
      if (!aborted) exp_wr.push_back(rdata);
      chk("rready_high", rready, 1);
      beat_idx++; xfer_beats++; r_budget--;
      if (rlast) begin
        void'(pend.pop_front());
        beat_in_burst = 0;
        last_rlast_cyc = cyc;
      end else beat_in_burst++;
    end

    fifo_alfull = force_alfull || (ar_count >= alfull_at_ar);
    arready = (ar_count < ar_limit);
    prev_arv_wait = arvalid && !arready;
    prev_araddr = araddr;
    prev_arlen = arlen;
    if (arvalid && arready) begin
      ar_count++;
      chk("arsize", arsize, 3);
      chk("arburst", arburst, 1);
      chk("arid", arid, 0);
      if (exp_ar.size() == 0) chk("ar_unexpected", 1, 0);
      else begin
        b = exp_ar.pop_front();
        chk("araddr", araddr, b.addr);
        chk("arlen", arlen, b.len);
      end
      pend.push_back('{araddr, int'(arlen)});
    end
  end

  task automatic do_start(input logic [31:0] s, input logic [31:0] e, input bit with_abort);
    @(negedge clk);
    addrstart = s; addrend = e; start = 1'b1; abort = with_abort;
    ar_count = 0; wr_count = 0; done_cnt = 0; xfer_beats = 0; beat_idx = 0;
    arv_cycles = 0; aborted = 1'b0;
    exp_ar.delete();
    gen_ars(s, e);
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
  endtask

  task automatic wait_idle(input int max);
    int i = 0;
    while (busy === 1'b1 && i < max) begin
      @(negedge clk);
      i++;
    end
    chk("idle_timeout_busy", busy, 0);
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_ar(input int n, input int max);
    int i = 0;
    while (ar_count < n && i < max) begin
      @(negedge clk);
      i++;
    end
    chk("ar_wait_timeout", ar_count >= n, 1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    resetn = 1'b0; start = 1'b0; abort = 1'b0; addrstart = '0; addrend = '0;
    rid = '0; rdata = '0; rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00;
    arready = 1'b0; fifo_alfull = 1'b0;
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    chk("rst_busy", busy, 0);      chk("rst_done", done, 0);
    chk("rst_err", err, 0);        chk("rst_fifo_wren", fifo_wren, 0);
    chk("rst_arvalid", arvalid, 0); chk("rst_araddr", araddr, 0);
    chk("rst_arlen", arlen, 0);    chk("rst_rready", rready, 1);
    chk("rst_fifo_di", fifo_di, 0); chk("rst_arsize", arsize, 3);

    // Aligned 512-byte window: four full bursts.
    do_start(32'h1000, 32'h1200, 1'b0);
    chk("t1_model_count", exp_ar.size(), 4);
    chk("t1_model_last_addr", exp_ar[3].addr, 32'h1180);
    chk("t1_model_len", exp_ar[0].len, 15);
    wait_idle(400);
    chk("t1_ar_count", ar_count, 4);  chk("t1_writes", wr_count, 64);
    chk("t1_done", done_cnt, 1);      chk("t1_ar_left", exp_ar.size(), 0);
    chk("t1_wr_left", exp_wr.size(), 0); chk("t1_err", err, 0);

    // 4 KB crossing.
    do_start(32'h1FC0, 32'h2100, 1'b0);
    chk("t2_model_count", exp_ar.size(), 3);
    chk("t2_model_len0", exp_ar[0].len, 7);
    chk("t2_model_addr1", exp_ar[1].addr, 32'h2000);
    wait_idle(400);
    chk("t2_ar_count", ar_count, 3); chk("t2_writes", wr_count, 40); chk("t2_done", done_cnt, 1);

    // Unaligned ends, short tail.
    do_start(32'h1003, 32'h1018, 1'b0);
    chk("t3_model_addr", exp_ar[0].addr, 32'h1000);
    chk("t3_model_len", exp_ar[0].len, 2);
    wait_idle(200);
    chk("t3_ar_count", ar_count, 1); chk("t3_writes", wr_count, 3); chk("t3_done", done_cnt, 1);

    // Outstanding limit.
    r_en = 1'b0;
    do_start(32'h0, 32'h1000, 1'b0);
    repeat (40) @(negedge clk);
    chk("t4_outst_cap", ar_count, 4); chk("t4_arvalid_idle", arvalid, 0);
    r_budget = 16; r_en = 1'b1;
    repeat (40) @(negedge clk);
    chk("t4_fifth_ar", ar_count, 5);
    r_budget = 1000000;
    wait_idle(3000);
    chk("t4_ar_count", ar_count, 32); chk("t4_writes", wr_count, 512); chk("t4_done", done_cnt, 1);

    // FIFO almost-full throttling and AR hold.
    r_en = 1'b0; ar_limit = 1; force_alfull = 1'b1;
    do_start(32'h1000, 32'h1200, 1'b0);
    repeat (20) @(negedge clk);
    chk("t5_no_arvalid", arv_cycles, 0);
    force_alfull = 1'b0;
    repeat (20) @(negedge clk);
    chk("t5_resumed", ar_count, 1); chk("t5_ar2_pending", arvalid, 1);
    force_alfull = 1'b1;
    repeat (5) @(negedge clk);
    chk("t5_not_withdrawn", arvalid, 1);
    ar_limit = 1000000;
    repeat (10) @(negedge clk);
    chk("t5_pending_done", ar_count, 2); chk("t5_no_third", arvalid, 0);
    r_en = 1'b1;
    repeat (40) @(negedge clk);
    chk("t5_inflight_written", wr_count, 32); chk("t5_still_two", ar_count, 2);
    force_alfull = 1'b0;
    wait_idle(400);
    chk("t5_writes", wr_count, 64); chk("t5_ar_count", ar_count, 4); chk("t5_done", done_cnt, 1);

    // Abort with one burst half returned.
    r_en = 1'b0; alfull_at_ar = 2;
    do_start(32'h1000, 32'h1400, 1'b0);
    wait_ar(2, 50);
    repeat (10) @(negedge clk);
    chk("t6_two_ars", ar_count, 2); chk("t6_arvalid_low", arvalid, 0);
    r_budget = 8; r_en = 1'b1;
    repeat (20) @(negedge clk);
    chk("t6_half_written", wr_count, 8);
    r_en = 1'b0;
    @(negedge clk);
    abort = 1'b1; aborted = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    repeat (5) @(negedge clk);
    chk("t6_busy_while_draining", busy, 1);
    r_budget = 1000000; alfull_at_ar = 1000000; r_en = 1'b1;
    wait_idle(200);
    chk("t6_ar_count", ar_count, 2); chk("t6_writes", wr_count, 8); chk("t6_no_done", done_cnt, 0);

    // Start wins over a coincident abort; normal run after an abort.
    do_start(32'h1000, 32'h1200, 1'b1);
    wait_idle(400);
    chk("t7_writes", wr_count, 64); chk("t7_done", done_cnt, 1); chk("t7_ar_count", ar_count, 4);

    // Error response on the 5th beat.
    bad_beat = 4;
    do_start(32'h1000, 32'h1200, 1'b0);
    wait_idle(400);
    bad_beat = -1;
    repeat (3) @(negedge clk);
    chk("t8_err_sticky", err, 1); chk("t8_writes", wr_count, 64); chk("t8_done", done_cnt, 1);

    // Empty window.
    do_start(32'h2000, 32'h1000, 1'b0);
    chk("t9_done_early", done, 0); chk("t9_busy", busy, 1); chk("t9_err_cleared", err, 0);
    @(negedge clk);
    chk("t9_done", done, 1); chk("t9_busy_low", busy, 0);
    repeat (5) @(negedge clk);
    chk("t9_no_ar", ar_count, 0); chk("t9_done_count", done_cnt, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
